// File: rtl/expr_pkg.sv
// Shared definitions for the expression checker/evaluator family.
// Holds the evaluator state enum, the 2-bit character-class encoding
// (shared with the syntax checker) and the ASCII constants used by the
// character decoder.
package expr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OPND = 2'b01,
    OPER = 2'b10,
    ERR  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    BAD = 2'b00,
    ADD = 2'b01,
    MUL = 2'b10,
    DIG = 2'b11
  } char_class_t;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_PLUS = 8'h2B;
  localparam logic [7:0] ASCII_STAR = 8'h2A;

endpackage

// File: rtl/expr_char_class.sv
// Combinational character decoder shared by the checker and evaluator.
// Ports:
//   in   - ASCII character
//   cls  - character class (BAD/ADD/MUL/DIG)
//   d    - digit value, valid when cls == DIG, else 0
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0]  in,
  output char_class_t cls,
  output logic [3:0]  d
);

  always_comb begin
    cls = BAD;
    d   = '0;
    if (in >= ASCII_0 && in <= ASCII_9) begin
      cls = DIG;
      d   = 4'(in - ASCII_0);
    end else if (in == ASCII_PLUS) begin
      cls = ADD;
    end else if (in == ASCII_STAR) begin
      cls = MUL;
    end
  end

endmodule

// File: rtl/expr_eval.sv
// Streaming evaluator for "digit (op digit)*" expressions with '*' binding
// tighter than '+'. One character per in_vld cycle, no backpressure.
// Ports:
//   clk     - clock, rising edge
//   clr     - asynchronous active-high reset
//   in_vld  - character strobe
//   in      - ASCII character
//   ok      - consumed characters form a valid expression ending in a digit
//   result  - expression value mod 2^W (meaningful while ok = 1)
//   ovf     - sticky overflow flag
// Build option: define OVERFLOW_DETECT_EN to build overflow detection;
// otherwise ovf is tied to 0.
module expr_eval
  import expr_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_vld,
  input  logic [7:0]   in,
  output logic         ok,
  output logic [W-1:0] result,
  output logic         ovf
);

  state_t      state, state_n;
  char_class_t pend, pend_n;
  logic [W-1:0] sum, sum_n, prod, prod_n;
  char_class_t cls;
  logic [3:0]  d;
  logic [W-1:0] prod_mul, sum_add, result_n;

  expr_char_class u_class (
    .in  (in),
    .cls (cls),
    .d   (d)
  );

`ifdef OVERFLOW_DETECT_EN
  logic [W+3:0] mul_full;
  logic [W:0]   add_full, res_full;
  logic         ovf_hit;

  // Extra-wide datapaths expose the bits lost to wrap-around.
  assign mul_full = (W+4)'(prod) * (W+4)'(d);
  assign add_full = {1'b0, sum} + {1'b0, prod};
  assign res_full = {1'b0, sum_n} + {1'b0, prod_n};
  assign prod_mul = mul_full[W-1:0];
  assign sum_add  = add_full[W-1:0];
  assign result_n = res_full[W-1:0];

  assign ovf_hit = (state == OPER && cls == DIG && pend == MUL && |mul_full[W+3:W])
                || (state == OPND && cls == ADD && add_full[W])
                || (state_n == OPND && res_full[W]);

  always_ff @(posedge clk or posedge clr) begin
    if (clr)                    ovf <= 1'b0;
    else if (in_vld && ovf_hit) ovf <= 1'b1;
  end
`else
  assign prod_mul = prod * W'(d);
  assign sum_add  = sum + prod;
  assign result_n = sum_n + prod_n;
  assign ovf      = 1'b0;
`endif

  always_comb begin
    state_n = state;
    sum_n   = sum;
    prod_n  = prod;
    pend_n  = pend;
    case (state)
      IDLE: begin
        if (cls == DIG) begin
          sum_n   = '0;
          prod_n  = W'(d);
          state_n = OPND;
        end else begin
          state_n = ERR;
        end
      end
      OPND: begin
        case (cls)
          ADD: begin
            sum_n   = sum_add;
            pend_n  = ADD;
            state_n = OPER;
          end
          MUL: begin
            pend_n  = MUL;
            state_n = OPER;
          end
          default: state_n = ERR;
        endcase
      end
      OPER: begin
        if (cls == DIG) begin
          prod_n  = (pend == MUL) ? prod_mul : W'(d);
          state_n = OPND;
        end else begin
          state_n = ERR;
        end
      end
      default: state_n = ERR;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      sum    <= '0;
      prod   <= '0;
      pend   <= ADD;
      ok     <= 1'b0;
      result <= '0;
    end else if (in_vld) begin
      state <= state_n;
      sum   <= sum_n;
      prod  <= prod_n;
      pend  <= pend_n;
      if (state_n == OPND) begin
        ok     <= 1'b1;
        result <= result_n;
      end else begin
        ok <= 1'b0;
        // Operators keep the last value visible; errors clear it.
        if (state_n == ERR) result <= '0;
      end
    end
  end

endmodule
